// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: computes on accept, holds results in a 2-entry in-order buffer,
// and presents the head entry with Zero/Overflow/IllegalOp flags downstream.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] IllegalCnt
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             illegal;
    } entry_t;

    localparam entry_t EMPTY = '{result: {WIDTH{1'b0}}, zero: 1'b0, ovf: 1'b0, illegal: 1'b0};

    // Bit 3 of the op selects subtract: the adder sees ~B with carry-in 1.
    function automatic entry_t alu_compute(input logic [3:0]       op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH-1:0] sum;
        logic             ovf;
        entry_t           e;
        b_eff = op[3] ? ~b : b;
        sum   = a + b_eff + {{(WIDTH-1){1'b0}}, op[3]};
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        e     = EMPTY;
        case (op)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0010: e.result = a ^ b;
            4'b0011: e.result = ~(a ^ b);
            4'b0100, 4'b1100: begin
                e.result = sum;
                e.ovf    = ovf;
            end
            4'b1101: e.result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == {WIDTH{1'b0}});
        return e;
    endfunction

    entry_t           head_r, tail_r, head_s, tail_s, new_s;
    logic [1:0]       count_r, count_s;
    logic [CNT_W-1:0] ill_cnt_r, ill_cnt_s;
    logic             in_ready_r;
    logic             push_s, pop_s;

    assign push_s = in_valid && in_ready_r;
    assign pop_s  = (count_r != 2'd0) && out_ready;

    // Next-state for the buffer slots, occupancy and illegal-op counter.
    always_comb begin
        new_s     = alu_compute(ALU_Op, SrcA, SrcB);
        head_s    = head_r;
        tail_s    = tail_r;
        count_s   = count_r;
        ill_cnt_s = ill_cnt_r;
        if (push_s && pop_s) begin
            // Only reachable with one entry held: the new op replaces the head.
            head_s = new_s;
        end else if (push_s) begin
            if (count_r == 2'd0) begin
                head_s = new_s;
            end else begin
                tail_s = new_s;
            end
            count_s = count_r + 2'd1;
        end else if (pop_s) begin
            head_s  = tail_r;
            tail_s  = EMPTY;
            count_s = count_r - 2'd1;
        end else begin
            count_s = count_r;
        end
        if (push_s && new_s.illegal && (ill_cnt_r != {CNT_W{1'b1}})) begin
            ill_cnt_s = ill_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ill_cnt_s = ill_cnt_r;
        end
    end

    // State registers; in_ready is registered so it never depends on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r     <= EMPTY;
            tail_r     <= EMPTY;
            count_r    <= 2'd0;
            ill_cnt_r  <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
        end else begin
            head_r     <= head_s;
            tail_r     <= tail_s;
            count_r    <= count_s;
            ill_cnt_r  <= ill_cnt_s;
            in_ready_r <= (count_s != 2'd2);
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = (count_r != 2'd0);
    assign Result     = head_r.result;
    assign Zero       = head_r.zero;
    assign Overflow   = head_r.ovf;
    assign IllegalOp  = head_r.illegal;
    assign IllegalCnt = ill_cnt_r;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expected results are queued on accept and
// checked by an independent monitor whenever the DUT hands an entry downstream.
module tb_alu_exec_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   alu_op = 4'd0;
    logic [W-1:0] src_a = 32'd0;
    logic [W-1:0] src_b = 32'd0;
    logic         in_ready, out_valid, zero, overflow, illegal_op;
    logic [W-1:0] result;
    logic [7:0]   illegal_cnt;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        il;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   model_cnt = 0;
    bit   rnd_mode = 1'b0;

    alu_exec_stage #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_Op(alu_op), .SrcA(src_a), .SrcB(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(result), .Zero(zero), .Overflow(overflow),
        .IllegalOp(illegal_op), .IllegalCnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Reference: signed results computed in 64-bit and range-checked for overflow.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, full;
        sa   = longint'(signed'(a));
        sb   = longint'(signed'(b));
        e.r  = 32'd0;
        e.o  = 1'b0;
        e.il = 1'b0;
        case (op)
            4'h0: e.r = a & b;
            4'h1: e.r = a | b;
            4'h2: e.r = a ^ b;
            4'h3: e.r = ~(a ^ b);
            4'h4: begin
                full = sa + sb;
                e.r  = 32'(full);
                e.o  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'hC: begin
                full = sa - sb;
                e.r  = 32'(full);
                e.o  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'hD: e.r = (sa < sb) ? 32'd1 : 32'd0;
            default: e.il = 1'b1;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int waits);
        exp_t e;
        bit   done;
        in_valid = 1'b1;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
        waits    = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(op, a, b);
                q.push_back(e);
                if (e.il && model_cnt < 255) model_cnt++;
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 500) begin
                    tests++;
                    fails++;
                    $display("FAIL issue_timeout: got no in_ready after %0d cycles expected accept", waits);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d entries pending expected 0", q.size());
        end
    endtask

    // Monitor: every downstream handshake pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got Result %h expected no output", result);
            end else begin
                mon_e = q.pop_front();
                chk("result", result, mon_e.r);
                chk1("zero", zero, mon_e.z);
                chk1("overflow", overflow, mon_e.o);
                chk1("illegal_op", illegal_op, mon_e.il);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [31:0] held;
        logic [31:0] corners [4];
        logic [3:0]  legal [7];
        logic [3:0]  op;
        logic [31:0] a, b;
        corners = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        legal   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'hD};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk("rst_result", result, 32'd0);
        chk1("rst_zero", zero, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        chk1("rst_illegal", illegal_op, 1'b0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single ADD with signed overflow, out_valid for exactly one cycle
        out_ready = 1'b1;
        issue(4'b0100, 32'h7FFF_FFFF, 32'h0000_0001, w);
        @(negedge clk);
        chk1("add_out_valid", out_valid, 1'b1);
        chk("add_result_direct", result, 32'h8000_0000);
        @(negedge clk);
        chk1("add_one_cycle", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // SUB / SLT back-to-back, one per cycle
        issue(4'b1100, 32'd5, 32'd5, w);
        chk("b2b_wait0", w, 32'd0);
        issue(4'b1101, 32'hFFFF_FFFF, 32'd1, w);
        chk("b2b_wait1", w, 32'd0);
        issue(4'b1101, 32'd1, 32'hFFFF_FFFF, w);
        chk("b2b_wait2", w, 32'd0);
        drain();

        // Logic ops
        for (int i = 0; i < 4; i++) issue(4'(i), 32'hF0F0_F0F0, 32'hFF00_FF00, w);
        drain();

        // Backpressure: third op held while buffer full, head stable
        out_ready = 1'b0;
        issue(4'b0100, 32'h0000_1111, 32'h0000_2222, w);
        issue(4'b1100, 32'h0000_0010, 32'h0000_0020, w);
        in_valid = 1'b1;
        alu_op   = 4'b0010;
        src_a    = 32'hAAAA_5555;
        src_b    = 32'h0F0F_0F0F;
        @(negedge clk);
        held = result;
        chk("bp_head", held, 32'h0000_3333);
        for (int i = 0; i < 3; i++) begin
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk("bp_head_stable", result, 32'h0000_3333);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(4'b0010, 32'hAAAA_5555, 32'h0F0F_0F0F, w);
        drain();

        // Randomized ops with random backpressure and idle gaps
        rnd_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 6)] : 4'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            issue(op, a, b, w);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("rand_illegal_cnt", 32'(illegal_cnt), model_cnt);

        // Illegal ops saturate the counter
        for (int i = 0; i < 300; i++) issue(4'b0111, $urandom, $urandom, w);
        drain();
        chk("illegal_cnt_model", 32'(illegal_cnt), model_cnt);
        chk("illegal_cnt_sat", 32'(illegal_cnt), 32'd255);

        // Reset with two buffered entries
        out_ready = 1'b0;
        issue(4'b0111, 32'd1, 32'd2, w);
        issue(4'b0100, 32'h7FFF_FFFF, 32'h7FFF_FFFF, w);
        rst_n = 1'b0;
        q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk1("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_result", result, 32'd0);
        chk1("mid_rst_zero", zero, 1'b0);
        chk1("mid_rst_overflow", overflow, 1'b0);
        chk1("mid_rst_illegal", illegal_op, 1'b0);
        chk("mid_rst_cnt", 32'(illegal_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("mid_rst_ready_after", in_ready, 1'b1);
        chk1("mid_rst_no_stale", out_valid, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        issue(4'b1100, 32'd3, 32'd10, w);
        drain();
        chk("final_queue_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
